apb4_pwm_mc: RTL
================

APB4_PWM_MC -- requirements
Module: apb4_pwm_mc

Interface
REQ-001 The block SHALL use one clock, clk_i, and a synchronous, active-high reset, rst_i; no other clock or reset exists.
REQ-002 Parameter CH_NUM, default 4, SHALL set the PWM channel count; legal range 1..8.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the width of the counter, period (CMP) and compare (CRx) registers; legal range 2..32.
REQ-004 Parameter PSCR_WIDTH, default 16, SHALL set the prescaler register width.
REQ-005 Ports, clock and reset first, SHALL be as follows.
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  APB write
- paddr  in  32  byte address; only [7:2] decoded
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  tied 1
- pslverr  out  1  tied 0
- pwm_o  out  CH_NUM  PWM outputs
- irq_o  out  1  period interrupt

Function
REQ-006 Register map SHALL be: 0x00 CTRL; 0x04 PSCR; 0x08 CNT (read-only); 0x0C CMP; 0x10 STAT; 0x14 CHCFG; 0x20+4*x CRx for x < CH_NUM.
- Writes to unmapped addresses and to CNT SHALL be ignored.
- Reads of unmapped addresses SHALL return 0.
REQ-007 CTRL bits SHALL be: [0] OVIE, [1] EN, [2] CLR, [3] MODE (0 = edge-aligned, 1 = center-aligned).
REQ-008 CHCFG bits SHALL be: [CH_NUM-1:0] per-channel enable; [8+x] channel x polarity.
REQ-009 Write handshake is psel&penable&pwrite. The register SHALL update on the next clk_i edge.
REQ-010 prdata SHALL be combinational during psel&penable&~pwrite, and 0 otherwise.
REQ-011 A tick SHALL occur every max(PSCR,1) clk_i cycles while EN=1.
- The prescaler SHALL restart from 0 on any PSCR write, on CLR, or when EN=0.
REQ-012 Edge mode, on each tick: CNT SHALL increment and wrap to 0 after CMP-1.
- The period event is a tick with CNT==CMP-1.
REQ-013 Center mode, on each tick: CNT SHALL count up 0..CMP, then down to 0, with a direction flag reversing at CMP and at 0.
- The period event is a tick with CNT==1 while counting down.
REQ-014 CMP==0 SHALL hold CNT at 0, generate no period events, and force all channels inactive.
REQ-015 Raw channel level SHALL be (CNT >= CRx).
- pwm_o[x] SHALL be raw^pol[x] when EN=1 and enable[x]=1; otherwise pol[x].
- pwm_o SHALL be registered: one clk_i of latency from CNT to pwm_o.
REQ-016 CLR SHALL be self-clearing and always read 0. Writing CLR=1 SHALL zero CNT, the prescaler and the direction flag on the next edge, regardless of EN.
REQ-017 CNT SHALL hold its value while EN=0.
REQ-018 STAT[0] OVIF SHALL be set by a period event and cleared by writing 1 to it (W1C). If set and clear happen in the same cycle, set SHALL win.
REQ-019 irq_o SHALL be OVIF & OVIE, registered.

Reset
REQ-020 On rst_i=1 at a clk_i edge, all registers, CNT, the prescaler, the direction flag and OVIF SHALL be 0.
- After reset, pwm_o=0, irq_o=0 and prdata=0.
REQ-021 Asserting rst_i mid-period SHALL abort the period with no event, and the outputs SHALL be idle on the next edge.

Configuration
REQ-022 With macro PWM_SHADOW_EN defined:
- CMP and CRx writes SHALL go to shadow registers.
- Active values SHALL load from the shadows on a period event, and also immediately whenever EN=0 or on CLR.
- Reads SHALL return the shadow values.
REQ-023 Without PWM_SHADOW_EN, CMP and CRx writes SHALL take effect on the next clk_i edge, and reads SHALL return the active values.

Verification
REQ-024 Edge mode, PSCR=0, CMP=10, CR0=4, ch0 enabled, pol=0 -> pwm_o[0] is low 4 cycles, then high 6 cycles, repeating; OVIF sets every 10 cycles.
REQ-025 Center mode, CMP=8, CR1=6, PSCR=2 -> CNT goes 0..8..0 with one step every 2 clk_i; ch1 is high for CNT 6..8..6, a width of 5 ticks centred on the peak.
REQ-026 Shadow on: change CMP from 10 to 5 when CNT=3 -> the current period completes at 10 and the next wraps at 5; shadow off -> wraps at 5 immediately (CNT=3 < 4).
REQ-027 OVIE=1: period event -> irq_o=1; W1C write to STAT in the same cycle as a new event -> OVIF stays 1.
REQ-028 CLR pulse at CNT=7, then rst_i pulse mid-period -> CNT=0 on the next edge; after reset, pwm_o=0, irq_o=0 and all registers read 0.
REQ-029 CMP=0 with EN=1, ch0 enabled, pol[0]=1 -> CNT holds 0, no OVIF, pwm_o[0]=1.

Source files
------------

// File: rtl/apb4_pwm_mc.sv
// apb4_pwm_mc: APB4 multi-channel PWM timer with a shared prescaler and counter
// (edge- or center-aligned), per-channel compare/polarity, and a period interrupt.
// Optional build macro PWM_SHADOW_EN double-buffers CMP and CRx so that new values
// take effect on a period boundary instead of mid-period.

// Per-channel compare register and registered PWM output.
module apb4_pwm_mc_ch #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] wdata,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 run,
  input  logic                 pol,
  output logic [CNT_WIDTH-1:0] rd,
  output logic                 pwm
);
  logic [CNT_WIDTH-1:0] cr;

`ifdef PWM_SHADOW_EN
  logic [CNT_WIDTH-1:0] cr_sh;
  // Shadow takes bus writes; active copy follows it on load (a same-cycle write is forwarded)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cr_sh <= '0;
      cr    <= '0;
    end else begin
      if (wr) cr_sh <= wdata;
      if (load) cr <= wr ? wdata : cr_sh;
    end
  end
  assign rd = cr_sh;
`else
  logic unused_load;
  assign unused_load = load;
  // Compare value updates directly from the bus
  always_ff @(posedge clk_i) begin
    if (rst_i)   cr <= '0;
    else if (wr) cr <= wdata;
  end
  assign rd = cr;
`endif

  // Idle level is the polarity bit; when running, raw level is inverted by polarity
  always_ff @(posedge clk_i) begin
    if (rst_i) pwm <= 1'b0;
    else       pwm <= run ? ((cnt >= cr) ^ pol) : pol;
  end
endmodule

module apb4_pwm_mc #(
  parameter int CH_NUM     = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int PSCR_WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [CH_NUM-1:0] pwm_o,
  output logic              irq_o
);
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  logic [5:0]            addr;
  logic                  wr_en, rd_en, clr;
  logic                  wr_ctrl, wr_pscr, wr_cmp, wr_stat, wr_chcfg;
  logic [CH_NUM-1:0]     wr_cr;
  logic                  ovie, en, mode, ovif, dir;
  logic                  tick, psc_last, period, load, cmp_zero;
  logic [PSCR_WIDTH-1:0] pscr, psc;
  cnt_t                  cnt, cmp, cmp_rd;
  logic [CH_NUM-1:0]     chen, pol;
  logic [CH_NUM-1:0][CNT_WIDTH-1:0] cr_rd;
  logic [31:0]           chcfg_rd;
  logic                  unused_bits;

  assign addr     = paddr[7:2];
  assign wr_en    = psel & penable & pwrite;
  assign rd_en    = psel & penable & ~pwrite;
  assign wr_ctrl  = wr_en && (addr == 6'd0);
  assign wr_pscr  = wr_en && (addr == 6'd1);
  assign wr_cmp   = wr_en && (addr == 6'd3);
  assign wr_stat  = wr_en && (addr == 6'd4);
  assign wr_chcfg = wr_en && (addr == 6'd5);
  assign clr      = wr_ctrl & pwdata[2];
  assign pready   = 1'b1;
  assign pslverr  = 1'b0;
  assign unused_bits = ^{paddr[31:8], paddr[1:0], pwdata};

  // Control, prescaler and channel configuration registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovie <= 1'b0;
      en   <= 1'b0;
      mode <= 1'b0;
      pscr <= '0;
      chen <= '0;
      pol  <= '0;
    end else begin
      if (wr_ctrl) begin
        ovie <= pwdata[0];
        en   <= pwdata[1];
        mode <= pwdata[3];
      end
      if (wr_pscr) pscr <= PSCR_WIDTH'(pwdata);
      if (wr_chcfg) begin
        chen <= pwdata[CH_NUM-1:0];
        pol  <= pwdata[8 +: CH_NUM];
      end
    end
  end

  // Active values reload at period end, whenever stopped, and on CLR
  assign load = period | ~en | clr;

`ifdef PWM_SHADOW_EN
  cnt_t cmp_sh;
  // Period register: shadow written by bus, active copy loaded on boundaries
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_sh <= '0;
      cmp    <= '0;
    end else begin
      if (wr_cmp) cmp_sh <= cnt_t'(pwdata);
      if (load) cmp <= wr_cmp ? cnt_t'(pwdata) : cmp_sh;
    end
  end
  assign cmp_rd = cmp_sh;
`else
  // Period register updates directly from the bus
  always_ff @(posedge clk_i) begin
    if (rst_i)       cmp <= '0;
    else if (wr_cmp) cmp <= cnt_t'(pwdata);
  end
  assign cmp_rd = cmp;
`endif

  assign cmp_zero = (cmp == '0);
  // PSCR of 0 or 1 both mean a tick every cycle
  assign psc_last = (pscr <= PSCR_WIDTH'(1)) || (psc >= pscr - PSCR_WIDTH'(1));
  assign tick     = en & psc_last;
  assign period   = tick & ~clr & ~cmp_zero &
                    (mode ? (dir && (cnt == cnt_t'(1))) : (cnt == cmp - cnt_t'(1)));

  // Prescaler restarts on PSCR write, CLR, or while disabled
  always_ff @(posedge clk_i) begin
    if (rst_i || clr || wr_pscr || !en) psc <= '0;
    else if (psc_last)                  psc <= '0;
    else                                psc <= psc + PSCR_WIDTH'(1);
  end

  // Main counter: edge mode wraps at CMP-1; center mode ramps 0..CMP..0.
  // The >= compares let a CMP shrunk below CNT wrap/turn around cleanly.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
      dir <= 1'b0;
    end else if (tick) begin
      if (cmp_zero) begin
        cnt <= '0;
        dir <= 1'b0;
      end else if (!mode) begin
        cnt <= (cnt >= cmp - cnt_t'(1)) ? '0 : cnt + cnt_t'(1);
        dir <= 1'b0;
      end else if (!dir) begin
        cnt <= cnt + cnt_t'(1);
        if (cnt >= cmp - cnt_t'(1)) dir <= 1'b1;
      end else if (cnt <= cnt_t'(1)) begin
        cnt <= '0;
        dir <= 1'b0;
      end else begin
        cnt <= cnt - cnt_t'(1);
      end
    end
  end

  // Overflow flag: W1C, a simultaneous period event wins; irq is registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovif  <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (period)                      ovif <= 1'b1;
      else if (wr_stat && pwdata[0])   ovif <= 1'b0;
      irq_o <= ovif & ovie;
    end
  end

  for (genvar x = 0; x < CH_NUM; x++) begin : g_ch
    assign wr_cr[x] = wr_en && (addr == 6'(8 + x));
    apb4_pwm_mc_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .wr    (wr_cr[x]),
      .wdata (cnt_t'(pwdata)),
      .load  (load),
      .cnt   (cnt),
      .run   (en & chen[x] & ~cmp_zero),
      .pol   (pol[x]),
      .rd    (cr_rd[x]),
      .pwm   (pwm_o[x])
    );
  end

  // CHCFG readback image
  always_comb begin
    chcfg_rd = '0;
    chcfg_rd[CH_NUM-1:0] = chen;
    chcfg_rd[8 +: CH_NUM] = pol;
  end

  // Combinational read mux, zero outside a read access phase
  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (addr)
        6'd0: prdata = {28'd0, mode, 1'b0, en, ovie};
        6'd1: prdata = 32'(pscr);
        6'd2: prdata = 32'(cnt);
        6'd3: prdata = 32'(cmp_rd);
        6'd4: prdata = {31'd0, ovif};
        6'd5: prdata = chcfg_rd;
        default: begin
          for (int x = 0; x < CH_NUM; x++)
            if (addr == 6'(8 + x)) prdata = 32'(cr_rd[x]);
        end
      endcase
    end
  end
endmodule
